// File: rtl/ysyx_22040125_ifu_fetch.sv
// ysyx_22040125_ifu_fetch
// Instruction fetch stage plus IF/ID pipeline register for the RV64 core.
// Keeps the PC, issues one instruction-memory request at a time, buffers a
// response that arrives during a load-use stall, and presents the fetched
// instruction to decode.
//
// Optional feature macro: YSYX_IFU_PERF_CNT_EN adds the perf_fetch_cnt
// output, a 64-bit count of instructions loaded into IF/ID.
//
// Ports:
//   clk          in   core clock, rising-edge
//   rst          in   synchronous active-high reset
//   stall        in   hold IF/ID and PC (load-use hazard)
//   redirect     in   taken branch/jump from EXE, flushes fetch
//   redirect_pc  in   64-bit redirect target
//   imem_req     out  fetch request valid
//   imem_addr    out  fetch address (current pc)
//   imem_ready   in   memory accepts the request this cycle
//   imem_rvalid  in   response data valid
//   imem_rdata   in   32-bit instruction word
//   id_valid     out  IF/ID holds a valid instruction
//   id_pc        out  PC of the IF/ID instruction
//   id_inst      out  IF/ID instruction word
//   dbg_state    out  current FSM state (0=REQ, 1=WAIT, 2=HOLD)
//   perf_fetch_cnt out (YSYX_IFU_PERF_CNT_EN only) loaded-instruction count
//
// Handshake: a request transfers in a cycle where imem_req=1 and
// imem_ready=1; imem_addr is held while imem_req=1 and imem_ready=0 (a
// redirect may change it). Exactly one response (imem_rvalid=1) follows each
// transferred request; imem_rvalid is ignored unless a request is outstanding.

module ysyx_22040125_ifu_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [63:0] id_pc,
    output logic [31:0] id_inst,
    output logic [1:0]  dbg_state
`ifdef YSYX_IFU_PERF_CNT_EN
    ,
    output logic [63:0] perf_fetch_cnt
`endif
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        kill;
    logic        kill_next;
    logic [63:0] pc;
    logic [63:0] pc_next;
    logic [31:0] buf_inst;
    logic [31:0] buf_next;
    logic        load;
    logic [31:0] load_inst;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_REQ;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; also computes the pc/kill/buffer updates and whether
    // IF/ID takes a new instruction this cycle.
    always_comb begin
        state_next = state;
        kill_next  = kill;
        pc_next    = pc;
        buf_next   = buf_inst;
        load       = 1'b0;
        load_inst  = imem_rdata;

        if (redirect) begin
            pc_next = redirect_pc;
            case (state)
                S_REQ: begin
                    // A request accepted in the redirect cycle is already in
                    // flight: wait for it and throw its data away.
                    if (imem_ready) begin
                        state_next = S_WAIT;
                        kill_next  = 1'b1;
                    end else begin
                        state_next = S_REQ;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        state_next = S_REQ;
                        kill_next  = 1'b0;
                    end else begin
                        state_next = S_WAIT;
                        kill_next  = 1'b1;
                    end
                end
                default: begin
                    state_next = S_REQ;
                end
            endcase
        end else begin
            case (state)
                S_REQ: begin
                    if (imem_ready) begin
                        state_next = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (kill) begin
                            kill_next  = 1'b0;
                            state_next = S_REQ;
                        end else if (!stall) begin
                            load       = 1'b1;
                            load_inst  = imem_rdata;
                            pc_next    = pc + 64'd4;
                            state_next = S_REQ;
                        end else begin
                            buf_next   = imem_rdata;
                            state_next = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        load       = 1'b1;
                        load_inst  = buf_inst;
                        pc_next    = pc + 64'd4;
                        state_next = S_REQ;
                    end
                end
                default: begin
                    state_next = S_REQ;
                end
            endcase
        end
    end

    // Output logic
    always_comb begin
        imem_req  = (state == S_REQ);
        imem_addr = pc;
        dbg_state = state;
    end

    // Datapath registers: pc, kill flag, stall buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            kill     <= 1'b0;
            buf_inst <= 32'd0;
        end else begin
            pc       <= pc_next;
            kill     <= kill_next;
            buf_inst <= buf_next;
        end
    end

    // IF/ID register. Redirect flushes, a load fills, stall holds, and an
    // unstalled cycle with nothing to load becomes a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_valid <= 1'b0;
            id_pc    <= 64'd0;
            id_inst  <= 32'd0;
        end else if (redirect) begin
            id_valid <= 1'b0;
        end else if (load) begin
            id_valid <= 1'b1;
            id_pc    <= pc;
            id_inst  <= load_inst;
        end else if (!stall) begin
            id_valid <= 1'b0;
        end
    end

`ifdef YSYX_IFU_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= 64'd0;
        end else if (load) begin
            perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_22040125_ifu_fetch.sv
// Testbench for ysyx_22040125_ifu_fetch: reactive memory model, random and
// directed stall/redirect/reset traffic, scoreboard of expected IF/ID loads.

module tb_ysyx_22040125_ifu_fetch;
    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [63:0] id_pc;
    logic [31:0] id_inst;
    logic [1:0]  dbg_state;
`ifdef YSYX_IFU_PERF_CNT_EN
    logic [63:0] perf_fetch_cnt;
`endif

    always #5 clk = ~clk;

    ysyx_22040125_ifu_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .id_valid    (id_valid),
        .id_pc       (id_pc),
        .id_inst     (id_inst),
        .dbg_state   (dbg_state)
`ifdef YSYX_IFU_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt)
`endif
    );

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [95:0] exp_q[$];   // {pc, inst} of responses that must reach IF/ID

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- stimulus knobs and model state ----------------
    int          ready_pct = 100;
    int          stall_pct = 0;
    int          redir_pct = 0;
    int          junk_pct  = 0;
    int          lat_min   = 1;
    int          lat_max   = 1;
    bit          mem_const = 1'b1;
    bit          use_fixed = 1'b0;
    logic [63:0] fixed_target = 64'd0;
    bit          rst_now = 1'b1;

    bit          outstanding = 1'b0;
    bit          out_killed  = 1'b0;
    logic [63:0] out_addr    = 64'd0;
    int          resp_wait   = 0;
    logic [63:0] exp_pc      = RESET_PC;
    logic [63:0] load_cnt    = 64'd0;
    bit          drv_load    = 1'b0;
    bit          prev_rst    = 1'b1;
    bit          prev_redirect = 1'b0;
    bit          prev_stall  = 1'b0;
    logic [96:0] snap        = '0;

    function automatic bit roll(input int pct);
        return ($urandom_range(99) < pct);
    endfunction

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (mem_const) return 32'h0000_0013;
        return a[33:2] ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [63:0] pick_target();
        logic [63:0] t;
        if (use_fixed) return fixed_target;
        case ($urandom_range(3))
            0: t = 64'h0000_0000_8000_1000;
            1: t = 64'hFFFF_FFFF_FFFF_FFF8;
            2: t = {$urandom(), $urandom()} & ~64'd3;
            default: t = RESET_PC + 64'($urandom_range(255)) * 64'd4;
        endcase
        return t;
    endfunction

    // ---------------- driver ----------------
    task automatic drive();
        rst         = rst_now;
        stall       = roll(stall_pct);
        redirect    = !rst_now && roll(redir_pct);
        redirect_pc = pick_target();
        imem_ready  = roll(ready_pct);
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom();
        if (rst_now) begin
            outstanding = 1'b0;
            out_killed  = 1'b0;
            exp_q.delete();
            exp_pc   = RESET_PC;
            load_cnt = 64'd0;
            if (roll(junk_pct)) imem_rvalid = 1'b1;
        end else begin
            if (outstanding) begin
                resp_wait--;
                if (resp_wait == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_word(out_addr);
                    outstanding = 1'b0;
                    if (!out_killed && !redirect) begin
                        exp_q.push_back({out_addr, imem_rdata});
                        exp_pc = out_addr + 64'd4;
                    end
                end
            end else if (roll(junk_pct)) begin
                imem_rvalid = 1'b1;
            end
            if (imem_req && imem_ready && !outstanding) begin
                outstanding = 1'b1;
                out_killed  = 1'b0;
                out_addr    = exp_pc;
                resp_wait   = $urandom_range(lat_max, lat_min);
            end
            if (redirect) begin
                exp_pc = redirect_pc;
                exp_q.delete();
                if (outstanding) out_killed = 1'b1;
            end
        end
        drv_load      = !rst_now && !redirect && !stall && (exp_q.size() > 0);
        prev_rst      = rst_now;
        prev_redirect = redirect;
        prev_stall    = stall;
    endtask

    // ---------------- monitor / compare ----------------
    task automatic observe();
        logic [95:0] e;
        bit exp_req;
        if (prev_rst) begin
            check("rst_id_valid", 96'(id_valid), 96'd0);
            check("rst_id_pc", 96'(id_pc), 96'd0);
            check("rst_id_inst", 96'(id_inst), 96'd0);
        end else if (prev_redirect) begin
            check("flush_id_valid", 96'(id_valid), 96'd0);
        end else if (prev_stall) begin
            check("stall_hold", 96'({id_valid, id_pc, id_inst}), 96'(snap));
        end else begin
            check("load_valid", 96'(id_valid), 96'(drv_load));
            if (drv_load) begin
                e = exp_q.pop_front();
                load_cnt++;
                check("id_pc", 96'(id_pc), 96'(e[95:32]));
                check("id_inst", 96'(id_inst), 96'(e[31:0]));
            end
        end
        exp_req = !outstanding && (exp_q.size() == 0);
        check("imem_req", 96'(imem_req), 96'(exp_req));
        if (exp_req) check("imem_addr", 96'(imem_addr), 96'(exp_pc));
`ifdef YSYX_IFU_PERF_CNT_EN
        check("perf_cnt", 96'(perf_fetch_cnt), 96'(load_cnt));
`endif
        snap = {id_valid, id_pc, id_inst};
    endtask

    task automatic tick();
        @(negedge clk);
        observe();
        drive();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic reach_wait(input string tag);
        for (int i = 0; i < 20 && !outstanding; i++) tick();
        check(tag, 96'(outstanding), 96'd1);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        drive();            // reset asserted from time 0
        run(3);
        rst_now = 1'b0;

        // back-to-back fetches, 1-cycle memory returning 0x00000013
        run(20);
        mem_const = 1'b0;

        // response during a multi-cycle stall goes to the buffer
        stall_pct = 100;
        run(5);
        stall_pct = 0;
        run(4);

        // redirect while waiting, response arrives two cycles later
        lat_min = 3; lat_max = 3;
        reach_wait("reach_wait_redir");
        use_fixed = 1'b1; fixed_target = 64'h0000_0000_8000_1000;
        redir_pct = 100;
        run(1);
        redir_pct = 0;
        run(8);

        // redirect together with stall
        lat_min = 1; lat_max = 1;
        stall_pct = 100; redir_pct = 100;
        run(1);
        stall_pct = 0; redir_pct = 0;
        run(6);

        // pc wrap at the top of the address space
        fixed_target = 64'hFFFF_FFFF_FFFF_FFF8;
        redir_pct = 100;
        run(1);
        redir_pct = 0;
        run(8);
        use_fixed = 1'b0;

        // memory not ready for several cycles
        ready_pct = 0;
        run(5);
        ready_pct = 100;
        run(4);

        // reset while a response is outstanding, then a late response
        lat_min = 4; lat_max = 4;
        reach_wait("reach_wait_rst");
        rst_now = 1'b1;
        run(1);
        rst_now = 1'b0;
        ready_pct = 0; junk_pct = 100;
        run(2);
        ready_pct = 100; junk_pct = 0;
        lat_min = 1; lat_max = 1;
        run(6);

        // random mix
        ready_pct = 70; stall_pct = 30; redir_pct = 8; junk_pct = 10;
        lat_min = 1; lat_max = 4;
        run(3000);

        // drain
        ready_pct = 100; stall_pct = 0; redir_pct = 0; junk_pct = 0;
        run(12);
        check("queue_empty", 96'(exp_q.size()), 96'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_22040125_ifu_fetch.md
# ysyx_22040125_ifu_fetch

Instruction fetch stage and IF/ID pipeline register for the five-stage RV64 core. Holds the PC, issues one instruction-memory request at a time, and presents the fetched instruction to decode. It consumes the hazard unit's load-use stall (`stall`) and the EXE redirect (`redirect`, asserted whenever the hazard unit's IF_Flush is active).

## Interface
- `RESET_PC`, 64'h0000_0000_8000_0000, PC loaded on reset.
- `clk`  in  1  Core clock; all state updates on its rising edge.
- `rst`  in  1  Reset; synchronous, active-high.
- `stall`  in  1  Hold IF/ID contents and PC (load-use hazard).
- `redirect`  in  1  Taken branch/jump from EXE; flush fetch.
- `redirect_pc`  in  64  Target PC, valid when `redirect`=1.
- `imem_req`  out  1  Fetch request valid.
- `imem_addr`  out  64  Fetch address (= current PC).
- `imem_ready`  in  1  Memory accepts request this cycle.
- `imem_rvalid`  in  1  Response data valid.
- `imem_rdata`  in  32  Instruction word.
- `id_valid`  out  1  IF/ID holds a valid instruction.
- `id_pc`  out  64  PC of the IF/ID instruction.
- `id_inst`  out  32  IF/ID instruction word.

## Operation
- FSM states: REQ, WAIT, HOLD.
- REQ: `imem_req`=1, `imem_addr`=pc. On `imem_ready` → WAIT. Otherwise stay.
- WAIT: `imem_req`=0. On `imem_rvalid`:
  - if `kill`=1, drop the data, clear `kill`, → REQ;
  - else if `stall`=0, load IF/ID (`id_valid`=1, `id_pc`=pc, `id_inst`=rdata), set pc+=4, → REQ;
  - else latch rdata into the one-entry buffer `buf_inst` → HOLD.
- HOLD: `imem_req`=0. When `stall`=0, load IF/ID from `buf_inst`, set pc+=4, → REQ.
- IF/ID while `stall`=1: `id_*` held unchanged.
- When no new instruction is loaded and `stall`=0: `id_valid` is cleared to 0 (bubble).
- Redirect (priority over `stall` and all states):
  - pc ← `redirect_pc`; `id_valid` ← 0; buffer discarded.
  - From REQ or HOLD: → REQ.
  - From WAIT with no `imem_rvalid` this cycle: set `kill`, stay in WAIT.
  - From WAIT with `imem_rvalid` this cycle: data dropped, → REQ.
  - REQ with `imem_ready`=1 in the redirect cycle: request is outstanding, so set `kill` and → WAIT.
- pc arithmetic: 64-bit modulo 2^64; pc+4 wraps 0xFFFF_FFFF_FFFF_FFFC → 0. No alignment check.

## Timing
- Reset values:
  - FSM=REQ; pc=`RESET_PC`; `kill`=0.
  - `id_valid`=0, `id_pc`=0, `id_inst`=0.
  - `imem_req`=1 in the first cycle after `rst` deasserts; `imem_addr`=`RESET_PC`.
- Reset mid-operation (any state, outstanding response pending): all state returns to reset values. A late `imem_rvalid` arriving in REQ is ignored.
- Latency: request accepted in cycle N, `imem_rvalid` in cycle N+k (k≥1) → `id_valid` rises at the edge ending cycle N+k.
- Peak throughput: one instruction per 2 cycles.
- `imem_addr` is stable while `imem_req`=1 and `imem_ready`=0, unless a redirect occurs.
- `imem_rvalid` outside WAIT is ignored.

## Configuration
- `YSYX_IFU_PERF_CNT_EN` defined:
  - Adds output `perf_fetch_cnt` (out, 64 bits).
  - Counts every instruction loaded into IF/ID with `id_valid`=1.
  - Reset to 0; wraps at 2^64.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Reset release, `imem_ready`=1, 1-cycle memory returning 0x00000013 → requests at 0x80000000, 0x80000004, …; `id_pc` follows with `id_valid`=1 every second cycle.
- Response arrives while `stall`=1 for 3 cycles → `id_*` held; after `stall` drops, `id_inst`=buffered word, `id_pc`=previous+4; no extra `imem_req` during HOLD.
- `redirect`=1 to 0x80001000 while in WAIT, response 2 cycles later → response dropped; next `imem_addr`=0x80001000; `id_valid`=0 for the flush.
- `redirect` and `stall` asserted together → redirect wins; `id_valid`=0; next fetch from `redirect_pc`.
- `imem_ready`=0 for 4 cycles → `imem_req`=1 and `imem_addr` constant; `rst` asserted in WAIT → `id_valid`=0, `imem_addr`=`RESET_PC` the next cycle.
- With `YSYX_IFU_PERF_CNT_EN`: 10 fetches including one dropped by a redirect → `perf_fetch_cnt`=9.
